// File: rtl/cache_arb_pkg.sv
// Shared types for the two-master cache arbiter: FSM encodings, master IDs
// and the winner-selection helper used in IDLE.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  localparam logic M_IFETCH = 1'b0;
  localparam logic M_DATA   = 1'b1;

  // Only one pending: that master. Both pending: alternate in round-robin
  // mode, otherwise the data master wins.
  function automatic logic pick_winner(input logic p0, input logic p1,
                                       input logic rr_en, input logic last);
    if (p0 && p1) begin
      return rr_en ? ~last : M_DATA;
    end else if (p1) begin
      return M_DATA;
    end else begin
      return M_IFETCH;
    end
  endfunction

endpackage

// File: rtl/cache_arb_slot.sv
// Per-master request slot: latches a single-cycle request, holds it pending
// until the arbiter takes it, generates the master's ready, flags pulses that
// arrive while the master is not ready, and holds the returned read data.
module cache_arb_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_a,
  input  logic [31:0] i_d,
  input  logic        i_we,
  input  logic        i_rd,
  input  logic        i_take,     // arbiter accepted this slot in IDLE
  input  logic        i_busy,     // this slot's request is in flight
  input  logic        i_load,     // read completion belongs to this slot
  input  logic [31:0] i_rdata,
  output logic [31:0] o_a,
  output logic [31:0] o_d,
  output logic        o_is_write,
  output logic        o_pending,
  output logic        o_ready,
  output logic        o_overrun,  // single-cycle: pulse dropped
  output logic [31:0] o_spo
);

  logic        r_pending;
  logic        r_is_write;
  logic [31:0] r_a;
  logic [31:0] r_d;
  logic [31:0] r_spo;
  logic        w_req;
  logic        w_capture;

  assign w_req      = i_we | i_rd;
  assign o_ready    = !r_pending && !i_busy;
  assign w_capture  = w_req && o_ready;
  assign o_overrun  = w_req && !o_ready;
  assign o_a        = r_a;
  assign o_d        = r_d;
  assign o_is_write = r_is_write;
  assign o_pending  = r_pending;
  assign o_spo      = r_spo;

  // Capture a request when ready; a take by the arbiter retires the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending  <= 1'b0;
      r_is_write <= 1'b0;
      r_a        <= '0;
      r_d        <= '0;
    end else if (i_take) begin
      r_pending <= 1'b0;
    end else if (w_capture) begin
      r_pending  <= 1'b1;
      r_is_write <= i_we;  // we+rd together counts as a write
      r_a        <= i_a;
      r_d        <= i_d;
    end
  end

  // Read data is held until the next read of this master completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_spo <= '0;
    end else if (i_load) begin
      r_spo <= i_rdata;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Two-master arbiter (instruction fetch m0, data m1) in front of the cache
// host port. Serialises latched requests onto the cache's pulse/ready
// handshake and watches for a cache that never comes back.
//
// Handshake: a master pulses mN_we/mN_rd for one cycle while mN_ready=1; the
// arbiter presents exactly one s_we/s_rd cycle (ISSUE) and then waits for
// s_ready=1 (WAIT) before completing; s_a/s_d stay stable throughout.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned RR      = 1,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_a,
  input  logic [31:0] m0_d,
  input  logic        m0_we,
  input  logic        m0_rd,
  output logic [31:0] m0_spo,
  output logic        m0_ready,
  input  logic [31:0] m1_a,
  input  logic [31:0] m1_d,
  input  logic        m1_we,
  input  logic        m1_rd,
  output logic [31:0] m1_spo,
  output logic        m1_ready,
  output logic [31:0] s_a,
  output logic [31:0] s_d,
  output logic        s_we,
  output logic        s_rd,
  input  logic [31:0] s_spo,
  input  logic        s_ready,
  output logic        grant,
  output logic        err_timeout,
  output logic        err_overrun,
  output state_e      o_dbg_state
);

  state_e      r_state;
  state_e      w_next;
  logic        r_grant;
  logic        r_is_write;
  logic        r_inflight;
  logic        r_last;
  logic [31:0] r_s_a;
  logic [31:0] r_s_d;
  logic [31:0] r_wd_cnt;
  logic        r_err_to;
  logic        r_err_ov;
  logic        w_s_we;
  logic        w_s_rd;
  logic        w_win;
  logic        w_start;
  logic        w_done;
  logic [31:0] w_a0, w_d0, w_a1, w_d1;
  logic        w_wr0, w_wr1, w_p0, w_p1, w_ov0, w_ov1;

  assign w_win   = pick_winner(w_p0, w_p1, RR != 0, r_last);
  assign w_start = (r_state == S_IDLE) && s_ready && (w_p0 || w_p1);
  assign w_done  = (r_state == S_WAIT) && s_ready;

  cache_arb_slot u_slot0 (
    .clk(clk), .rst(rst), .i_a(m0_a), .i_d(m0_d), .i_we(m0_we), .i_rd(m0_rd),
    .i_take(w_start && (w_win == M_IFETCH)),
    .i_busy(r_inflight && (r_grant == M_IFETCH)),
    .i_load(w_done && !r_is_write && (r_grant == M_IFETCH)),
    .i_rdata(s_spo), .o_a(w_a0), .o_d(w_d0), .o_is_write(w_wr0),
    .o_pending(w_p0), .o_ready(m0_ready), .o_overrun(w_ov0), .o_spo(m0_spo)
  );

  cache_arb_slot u_slot1 (
    .clk(clk), .rst(rst), .i_a(m1_a), .i_d(m1_d), .i_we(m1_we), .i_rd(m1_rd),
    .i_take(w_start && (w_win == M_DATA)),
    .i_busy(r_inflight && (r_grant == M_DATA)),
    .i_load(w_done && !r_is_write && (r_grant == M_DATA)),
    .i_rdata(s_spo), .o_a(w_a1), .o_d(w_d1), .o_is_write(w_wr1),
    .o_pending(w_p1), .o_ready(m1_ready), .o_overrun(w_ov1), .o_spo(m1_spo)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and the one-cycle cache strobe.
  always_comb begin
    w_next = r_state;
    w_s_we = 1'b0;
    w_s_rd = 1'b0;
    unique case (r_state)
      S_IDLE:  if (w_start) w_next = S_ISSUE;
      S_ISSUE: begin
        w_s_we = r_is_write;
        w_s_rd = !r_is_write;
        w_next = S_WAIT;
      end
      S_WAIT:  if (s_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Grant, cache address/data and in-flight bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant    <= M_IFETCH;
      r_is_write <= 1'b0;
      r_inflight <= 1'b0;
      r_last     <= M_DATA;  // m0 wins the first tie
      r_s_a      <= '0;
      r_s_d      <= '0;
    end else begin
      if (w_start) begin
        r_grant    <= w_win;
        r_is_write <= (w_win == M_DATA) ? w_wr1 : w_wr0;
        r_s_a      <= (w_win == M_DATA) ? w_a1 : w_a0;
        r_s_d      <= (w_win == M_DATA) ? w_d1 : w_d0;
        r_inflight <= 1'b1;
      end
      if (w_done) begin
        r_inflight <= 1'b0;
        r_last     <= r_grant;
      end
    end
  end

  // Watchdog: counts WAIT cycles without s_ready; the flag is sticky and the
  // FSM keeps waiting so a late s_ready still completes the transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt <= '0;
      r_err_to <= 1'b0;
    end else if (r_state == S_ISSUE) begin
      r_wd_cnt <= '0;
    end else if ((r_state == S_WAIT) && !s_ready) begin
      if (r_wd_cnt != '1) r_wd_cnt <= r_wd_cnt + 32'd1;
      if ((TIMEOUT != 0) && (r_wd_cnt == 32'(TIMEOUT - 1))) r_err_to <= 1'b1;
    end
  end

  // Sticky overrun flag from either slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_err_ov <= 1'b0;
    else if (w_ov0 | w_ov1) r_err_ov <= 1'b1;
  end

  assign s_a         = r_s_a;
  assign s_d         = r_s_d;
  assign s_we        = w_s_we;
  assign s_rd        = w_s_rd;
  assign grant       = r_grant;
  assign err_timeout = r_err_to;
  assign err_overrun = r_err_ov;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: two instances (round-robin and fixed priority,
// both with a 16-cycle watchdog) share master stimulus; each has its own
// cache model. Issued cache strobes are scoreboarded against exp_q0/exp_q1.
module tb_cache_arbiter;
  import cache_arb_pkg::*;

  localparam int EW = 66;  // {grant, we, addr, data}

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] m0_a = '0, m0_d = '0, m1_a = '0, m1_d = '0;
  logic m0_we = 1'b0, m0_rd = 1'b0, m1_we = 1'b0, m1_rd = 1'b0;

  logic [1:0][31:0] m0_spo, m1_spo, s_a, s_d, s_spo;
  logic [1:0] m0_ready, m1_ready, s_we, s_rd, s_ready, grant, err_timeout, err_overrun;
  logic [1:0][1:0] dbg_state;

  int   miss_len = 0;
  logic stuck = 1'b0;
  int   n_total = 0;
  int   n_bad = 0;
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] mon_got, mon_want;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic logic [31:0] rdata(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  function automatic logic [EW-1:0] iss(input logic gr, input logic we,
                                        input logic [31:0] a, input logic [31:0] d);
    return {gr, we, a, d};
  endfunction

  // ---------------- DUTs and cache models ----------------
  for (genvar g = 0; g < 2; g++) begin : g_dut
    int          cnt;
    logic        stk;
    logic [31:0] r_spo;

    cache_arbiter #(.RR((g == 0) ? 1 : 0), .TIMEOUT(16)) u_dut (
      .clk(clk), .rst(rst),
      .m0_a(m0_a), .m0_d(m0_d), .m0_we(m0_we), .m0_rd(m0_rd),
      .m0_spo(m0_spo[g]), .m0_ready(m0_ready[g]),
      .m1_a(m1_a), .m1_d(m1_d), .m1_we(m1_we), .m1_rd(m1_rd),
      .m1_spo(m1_spo[g]), .m1_ready(m1_ready[g]),
      .s_a(s_a[g]), .s_d(s_d[g]), .s_we(s_we[g]), .s_rd(s_rd[g]),
      .s_spo(s_spo[g]), .s_ready(s_ready[g]),
      .grant(grant[g]), .err_timeout(err_timeout[g]), .err_overrun(err_overrun[g]),
      .o_dbg_state(dbg_state[g])
    );

    // Cache: busy while a strobe is presented, then miss_len extra cycles.
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt   <= 0;
        stk   <= 1'b0;
        r_spo <= '0;
      end else if (s_rd[g] | s_we[g]) begin
        cnt <= miss_len;
        stk <= stuck;
        if (s_rd[g]) r_spo <= rdata(s_a[g]);
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
      end
    end
    assign s_spo[g]   = r_spo;
    assign s_ready[g] = !(s_rd[g] | s_we[g]) && (cnt == 0) && !stk;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe cycle pops one expected issue.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int g = 0; g < 2; g++) begin
          if (s_rd[g] | s_we[g]) begin
            mon_got  = {grant[g], s_we[g], s_a[g], s_d[g]};
            mon_want = '1;
            if (g == 0 && exp_q0.size() != 0) mon_want = exp_q0.pop_front();
            if (g == 1 && exp_q1.size() != 0) mon_want = exp_q1.pop_front();
            check($sformatf("u%0d_issue_ctl", g), 64'(mon_got[65:32]), 64'(mon_want[65:32]));
            check($sformatf("u%0d_issue_d", g), 64'(mon_got[31:0]), 64'(mon_want[31:0]));
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_both(input logic [EW-1:0] e);
    exp_q0.push_back(e);
    exp_q1.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    miss_len = 0;
    stuck = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One-cycle pulse on either or both masters.
  task automatic drive(input logic e0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic e1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    @(posedge clk);
    #1;
    m0_a = a0; m0_d = d0; m0_we = e0 & w0; m0_rd = e0 & !w0;
    m1_a = a1; m1_d = d1; m1_we = e1 & w1; m1_rd = e1 & !w1;
    @(posedge clk);
    #1;
    m0_we = 1'b0; m0_rd = 1'b0; m1_we = 1'b0; m1_rd = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!((&m0_ready) && (&m1_ready) && dbg_state[0] == 2'd0 && dbg_state[1] == 2'd0)
           && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(n >= 300), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t_sr, t_rdy, n_wait;
    logic [31:0] a0, a1;

    fork
      monitor();
    join_none

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_ready", 64'({m1_ready, m0_ready}), 64'(4'hF));
    check("rst_err", 64'({err_timeout, err_overrun}), 64'(0));
    check("rst_strobe_grant", 64'({grant, s_we, s_rd}), 64'(0));
    check("rst_data", 64'(m0_spo[0] | m1_spo[0] | s_a[0] | s_d[0]), 64'(0));

    // Single read, hit, with cycle-accurate latency
    push_both(iss(M_IFETCH, 1'b0, 32'h100, 32'h0));
    drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("t1_c1_ready", 64'(m0_ready[0]), 64'(0));
    @(negedge clk);
    check("t1_c2_srd", 64'(s_rd[0]), 64'(1));
    check("t1_c2_sa", 64'(s_a[0]), 64'(32'h100));
    @(negedge clk);
    check("t1_c3_srd", 64'(s_rd[0]), 64'(0));
    check("t1_c3_ready", 64'(m0_ready[0]), 64'(0));
    @(negedge clk);
    check("t1_c4_ready", 64'(m0_ready), 64'(2'b11));
    check("t1_c4_spo", 64'(m0_spo[0]), 64'(32'hDEAD_BEEF));
    // Pulse in the very cycle ready rose: must be captured
    push_both(iss(M_IFETCH, 1'b0, 32'h104, 32'h0));
    m0_a = 32'h104; m0_rd = 1'b1;
    @(posedge clk);
    #1 m0_rd = 1'b0;
    wait_idle("t1b_idle");
    check("t1b_spo0", 64'(m0_spo[0]), 64'(rdata(32'h104)));
    check("t1b_spo1", 64'(m0_spo[1]), 64'(rdata(32'h104)));
    check("t1b_no_overrun", 64'(err_overrun), 64'(0));

    // Miss: preload m1_spo with a read, then a 40-cycle write miss
    push_both(iss(M_DATA, 1'b0, 32'h300, 32'h0));
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0);
    wait_idle("t2a_idle");
    check("t2a_spo", 64'(m1_spo[0]), 64'(rdata(32'h300)));
    miss_len = 40;
    push_both(iss(M_DATA, 1'b1, 32'h2000, 32'h1234));
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'h1234);
    t_sr = -1;
    t_rdy = -1;
    for (int c = 1; c <= 80 && t_rdy < 0; c++) begin
      @(negedge clk);
      if (t_sr < 0 && c >= 3 && s_ready[0]) t_sr = c;
      if (m1_ready[0]) t_rdy = c;
    end
    check("t2_sready_cycle", 64'(t_sr), 64'(43));
    check("t2_ready_lag", 64'(t_rdy - t_sr), 64'(1));
    check("t2_spo_kept", 64'(m1_spo[0]), 64'(rdata(32'h300)));
    miss_len = 0;
    wait_idle("t2_idle");

    // Contention: both pulse together, four rounds
    do_reset();
    for (int r = 0; r < 4; r++) begin
      a0 = 32'h400 + 32'(r * 16);
      a1 = 32'h800 + 32'(r * 16);
      exp_q0.push_back(iss(M_IFETCH, 1'b0, a0, 32'h0));
      exp_q0.push_back(iss(M_DATA, 1'b0, a1, 32'h0));
      exp_q1.push_back(iss(M_DATA, 1'b0, a1, 32'h0));
      exp_q1.push_back(iss(M_IFETCH, 1'b0, a0, 32'h0));
      drive(1'b1, 1'b0, a0, 32'h0, 1'b1, 1'b0, a1, 32'h0);
      wait_idle("t3_idle");
      check("t3_rr_spo0", 64'(m0_spo[0]), 64'(rdata(a0)));
      check("t3_rr_spo1", 64'(m1_spo[0]), 64'(rdata(a1)));
      check("t3_fp_spo0", 64'(m0_spo[1]), 64'(rdata(a0)));
      check("t3_fp_spo1", 64'(m1_spo[1]), 64'(rdata(a1)));
    end

    // Overrun: two consecutive m0 pulses, only the first is taken
    do_reset();
    push_both(iss(M_IFETCH, 1'b0, 32'h600, 32'h0));
    @(posedge clk);
    #1 m0_a = 32'h600; m0_rd = 1'b1;
    @(posedge clk);
    #1 m0_a = 32'h700;
    @(posedge clk);
    #1 m0_rd = 1'b0;
    wait_idle("t4_idle");
    check("t4_overrun", 64'(err_overrun), 64'(2'b11));
    check("t4_spo", 64'(m0_spo[0]), 64'(rdata(32'h600)));
    repeat (5) @(negedge clk);
    check("t4_overrun_sticky", 64'(err_overrun), 64'(2'b11));

    // Watchdog: cache never returns ready after the strobe
    do_reset();
    stuck = 1'b1;
    push_both(iss(M_IFETCH, 1'b0, 32'h500, 32'h0));
    drive(1'b1, 1'b0, 32'h500, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_wait = 0;
    for (int c = 0; c < 60 && !err_timeout[0]; c++) begin
      @(negedge clk);
      if (dbg_state[0] == 2'd2 && !err_timeout[0]) n_wait++;
    end
    check("t5_wait_cycles", 64'(n_wait), 64'(16));
    check("t5_timeout", 64'(err_timeout[0]), 64'(1));
    // m1 requests stay pending; the second pulse is an overrun
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h900, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h904, 32'h0);
    repeat (20) @(negedge clk);
    check("t5_still_wait", 64'(dbg_state[0]), 64'(2'd2));
    check("t5_flags", 64'({err_timeout, err_overrun}), 64'(4'hF));
    check("t5_m1_blocked", 64'(m1_ready), 64'(0));

    // Asynchronous reset mid-WAIT, checked before any clock edge
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_strobe", 64'({s_we, s_rd}), 64'(0));
    check("t6_ready", 64'({m1_ready, m0_ready}), 64'(4'hF));
    check("t6_err", 64'({err_timeout, err_overrun}), 64'(0));
    check("t6_state", 64'(dbg_state), 64'(0));
    exp_q0.delete();
    exp_q1.delete();
    stuck = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    push_both(iss(M_IFETCH, 1'b0, 32'h100, 32'h0));
    drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_idle("t6_idle");
    check("t6_spo", 64'(m0_spo[0]), 64'(32'hDEAD_BEEF));
    check("t6_err_after", 64'({err_timeout, err_overrun}), 64'(0));

    repeat (3) @(negedge clk);
    check("q0_drained", 64'(exp_q0.size()), 64'(0));
    check("q1_drained", 64'(exp_q1.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Two-requester arbiter in front of the pCPU cache host port. Shares one cache between instruction fetch (m0) and data load/store (m1).
- Latches single-cycle requests from each master and serialises them onto the cache's pulse-request/ready handshake.
- Returns captured read data and a per-master ready to the requester.
- Sits between the CPU core and the cache; the cache's own burst side to lowmem is untouched.

Parameters:
- RR, default 1: 1 = round-robin between m0/m1; 0 = fixed priority, m1 (data) wins.
- TIMEOUT, default 4096: cycles in WAIT without s_ready before `err_timeout` sets; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- m0_a  in  32  master 0 byte address
- m0_d  in  32  master 0 write data
- m0_we  in  1  master 0 write pulse (one cycle)
- m0_rd  in  1  master 0 read pulse (one cycle)
- m0_spo  out  32  master 0 read data, held until its next request completes
- m0_ready  out  1  master 0 idle: no pending or in-flight request
- m1_a, m1_d, m1_we, m1_rd, m1_spo, m1_ready: same as m0 for master 1
- s_a  out  32  address to cache
- s_d  out  32  write data to cache
- s_we  out  1  write pulse to cache
- s_rd  out  1  read pulse to cache
- s_spo  in  32  cache read data
- s_ready  in  1  cache idle/complete; low while a pulse is presented and during a miss
- grant  out  1  0 = m0 owns the cache, 1 = m1; valid outside IDLE
- err_timeout  out  1  sticky watchdog flag
- err_overrun  out  1  sticky: a master pulsed while its ready was low

Behaviour:
- Reset (asynchronous) values: all state cleared; state = IDLE; `s_we`, `s_rd`, `grant`, `err_*` = 0; `s_a`, `s_d`, `mN_spo` = 0; pending bits = 0; `mN_ready` = 1; round-robin pointer favours m0.
- Request capture:
  - `mN_we | mN_rd` with `mN_ready` = 1 latches a, d and is_write into slot N and sets pending[N] on the next edge.
  - `mN_ready` = !pending[N] & !(inflight & grant == N).
  - we and rd together: treated as a write.
  - A pulse while `mN_ready` = 0 is dropped and sets `err_overrun`.
- IDLE:
  - Waits for `s_ready` = 1 and any pending bit.
  - Winner: only one pending → that one. Both pending → RR ? not last winner : m1.
  - Registers `grant`, `s_a`, `s_d`; clears pending[winner]; sets inflight; goes to ISSUE.
- ISSUE (exactly one cycle):
  - `s_we` or `s_rd` = 1 per the latched type; `s_a`/`s_d` stable.
  - Next state WAIT; watchdog counter cleared.
- WAIT:
  - `s_we`/`s_rd` = 0; `s_a`/`s_d` held.
  - On `s_ready` = 1: for a read, `mN_spo[grant]` <= `s_spo`; clear inflight; update the RR pointer; return to IDLE.
  - Counter increments each cycle. Reaching TIMEOUT (TIMEOUT != 0) sets `err_timeout`; the FSM stays in WAIT.
- Latency, pulse at cycle 0 with an idle cache and a hit:
  - pending set at edge 1; grant in cycle 1; `s_rd` high cycle 2; `s_ready` sampled cycle 3; `mN_ready` high and `mN_spo` valid cycle 4.
  - Misses add the cache's fill/writeback time.
- Concurrency:
  - A master may pulse in the same cycle the other master completes.
  - A master may pulse in the cycle right after its own ready rises; that pulse is captured.
  - Both masters pulsing the same cycle: both captured, arbitrated in IDLE.
- Cache init: `s_ready` = 0 holds the FSM in IDLE; requests remain pending.
- Reset mid-WAIT: everything clears asynchronously; the lost transaction is not reissued. The cache is reset by the same `rst`.
- Write completion: `mN_spo` unchanged.

Decomposition:
- Shared package `cache_arb_pkg`: FSM state encodings IDLE/ISSUE/WAIT; grant IDs M_IFETCH=0, M_DATA=1.
- One sub-module, `cache_arb_slot`: per-master latch for a/d/is_write, pending flag, ready generation and overrun detection. Instantiated twice.
- Arbitration FSM and watchdog live in the top module.

Test Plan:
- Single read, hit: m0_rd with m0_a=0x100; cache model hits and returns 0xDEADBEEF → s_rd pulses exactly one cycle with s_a=0x100; m0_ready returns at cycle 4; m0_spo=0xDEADBEEF.
- Miss latency: m1_we with a=0x2000, d=0x1234; s_ready held low 40 cycles → s_we pulses once; m1_ready stays low throughout and rises one cycle after s_ready returns; m1_spo unchanged.
- Contention, RR=1: both masters pulse the same cycle, repeated 4 times → grants m0,m1,m0,m1 (first-winner check). Same stimulus with RR=0 → m1 always granted first.
- Overrun: m0 pulses twice in consecutive cycles → second pulse ignored; only one s_rd issued; err_overrun=1 and stays set.
- Watchdog: TIMEOUT=16; s_ready stuck low after an issue → err_timeout set on the 16th WAIT cycle; no further s_rd/s_we issued.
- Reset: rst asserted mid-WAIT → same cycle (asynchronous) s_rd/s_we=0, both mN_ready=1, err flags=0; after release, a new m0 request completes normally.
